// File: rtl/cmp_pkg.sv
// Shared definitions for the serial magnitude comparator.
// Contents: FSM state encoding, result codes and a helper that maps a
// result code onto the one-hot {x, y, z} output vector.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    GT = 2'd0,
    EQ = 2'd1,
    LT = 2'd2
  } res_e;

  // Returns {x, y, z} = {a>b, a==b, a<b}
  function automatic logic [2:0] res_onehot(input res_e r);
    case (r)
      GT:      return 3'b100;
      EQ:      return 3'b010;
      LT:      return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/serial_mag_comparator_if.sv
// Handshake bus of the serial magnitude comparator.
//   in_valid/in_ready : operand-pair handshake, a/b operands (unsigned)
//   out_valid/out_ready : result handshake, x/y/z = a>b, a==b, a<b
// master : producer/consumer side (testbench or upstream logic)
// slave  : comparator side
interface serial_mag_comparator_if #(
  parameter int unsigned WIDTH = 4
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic             x;
  logic             y;
  logic             z;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, x, y, z
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, x, y, z
  );

endinterface

// File: rtl/bit_compare_cell.sv
// Combinational 1-bit magnitude compare cell.
//   ai, bi : operand bits
//   gt     : ai > bi
//   eq     : ai == bi
//   lt     : ai < bi
module bit_compare_cell (
  input  logic ai,
  input  logic bi,
  output logic gt,
  output logic eq,
  output logic lt
);

  assign gt = ai & ~bi;
  assign eq = ~(ai ^ bi);
  assign lt = ~ai & bi;

endmodule

// File: rtl/serial_mag_comparator.sv
// Serial MSB-first magnitude comparator with result counters.
// An accepted operand pair is scanned one bit per cycle from the MSB; the
// scan stops at the first differing bit (or after bit 0) and the result is
// presented on x/y/z until the consumer takes it.
//   clk, rst_n             : clock, asynchronous active-low reset
//   bus (slave modport)    : operand and result handshakes, see interface
//   clear                  : synchronous clear of the result counters
//   cnt_gt/cnt_eq/cnt_lt   : saturating counts of delivered results
module serial_mag_comparator
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  serial_mag_comparator_if.slave bus,
  input  logic                   clear,
  output logic [CNT_W-1:0]       cnt_gt,
  output logic [CNT_W-1:0]       cnt_eq,
  output logic [CNT_W-1:0]       cnt_lt
);

  localparam int unsigned     IDX_W   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

  state_e             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [IDX_W-1:0]   idx_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [2:0]         xyz_q;
  logic [CNT_W-1:0]   cnt_gt_q;
  logic [CNT_W-1:0]   cnt_eq_q;
  logic [CNT_W-1:0]   cnt_lt_q;

  logic               bit_gt;
  logic               bit_eq;
  logic               bit_lt;
  res_e               res_d;
  logic [2:0]         xyz_d;
  logic               scan_done;
  logic               out_hs;

  bit_compare_cell u_cell (
    .ai (a_q[idx_q]),
    .bi (b_q[idx_q]),
    .gt (bit_gt),
    .eq (bit_eq),
    .lt (bit_lt)
  );

  always_comb begin
    res_d = EQ;
    if (bit_gt) begin
      res_d = GT;
    end else if (bit_lt) begin
      res_d = LT;
    end
    xyz_d = res_onehot(res_d);
  end

  // A differing bit decides the result immediately; otherwise bit 0 ends the scan.
  assign scan_done = !bit_eq || (idx_q == '0);
  assign out_hs    = (state_q == DONE) && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      idx_q       <= IDX_MSB;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      xyz_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            idx_q      <= IDX_MSB;
            in_ready_q <= 1'b0;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          if (scan_done) begin
            xyz_q       <= xyz_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q - IDX_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            xyz_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          xyz_q       <= '0;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  // Clear takes priority over an increment on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_gt_q <= '0;
      cnt_eq_q <= '0;
      cnt_lt_q <= '0;
    end else if (clear) begin
      cnt_gt_q <= '0;
      cnt_eq_q <= '0;
      cnt_lt_q <= '0;
    end else if (out_hs) begin
      if (xyz_q[2] && (cnt_gt_q != '1)) cnt_gt_q <= cnt_gt_q + CNT_W'(1);
      if (xyz_q[1] && (cnt_eq_q != '1)) cnt_eq_q <= cnt_eq_q + CNT_W'(1);
      if (xyz_q[0] && (cnt_lt_q != '1)) cnt_lt_q <= cnt_lt_q + CNT_W'(1);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.x         = xyz_q[2];
  assign bus.y         = xyz_q[1];
  assign bus.z         = xyz_q[0];
  assign cnt_gt        = cnt_gt_q;
  assign cnt_eq        = cnt_eq_q;
  assign cnt_lt        = cnt_lt_q;

endmodule
